// File: rtl/zone_max_accum_pkg.sv
// Shared zone-geometry constants and brightness type for the MiniLED zone
// statistics path (zone_max_accum and the downstream backlight driver).
package zone_max_accum_pkg;

  typedef logic [7:0] bright_t;

  localparam int H_ACTIVE_DEF  = 1920;
  localparam int V_ACTIVE_DEF  = 1080;
  localparam int ZONE_COLS_DEF = 16;
  localparam int ZONE_ROWS_DEF = 9;

  localparam int ZONE_W     = H_ACTIVE_DEF / ZONE_COLS_DEF;
  localparam int ZONE_H     = V_ACTIVE_DEF / ZONE_ROWS_DEF;
  localparam int ZONE_N     = ZONE_COLS_DEF * ZONE_ROWS_DEF;
  localparam int ZONE_IDX_W = $clog2(ZONE_N);

  // Index width that never collapses to zero for single-entry ranges.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic bright_t bright_max(input bright_t a, input bright_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/zone_max_accum_flush.sv
// Flush side of the zone band bank: steps one finished band out over
// valid/ready, raises frame_done after the last zone and flags dropped bands.
module zone_flush_ctrl
  import zone_max_accum_pkg::*;
#(
  parameter int ZONE_COLS = 16,
  parameter int ZONE_N    = 144,
  parameter int IW        = 8
) (
  input  logic                          pixel_clk,
  input  logic                          sys_rst,
  input  logic                          band_end,
  input  bright_t                       start_val,
  input  logic [IW-1:0]                 base_idx,
  input  logic [ZONE_COLS-1:0][7:0]     rd_bank,
  output logic                          accept,
  output logic                          zone_vld,
  input  logic                          zone_rdy,
  output bright_t                       zone_val,
  output logic [IW-1:0]                 zone_idx,
  output logic                          frame_done,
  output logic                          overflow
);

  localparam int PW = idx_w(ZONE_COLS);

  logic [PW-1:0] ptr, ptr_nxt;
  logic          last, xfer;
  bright_t       rd_nxt;

  assign ptr_nxt = ptr + PW'(1);
  assign last    = (ptr == PW'(ZONE_COLS - 1));
  assign xfer    = zone_vld & zone_rdy;
  // A band ending on the very cycle the last zone leaves is still taken.
  assign accept  = band_end & (~zone_vld | (xfer & last));

  always_comb begin
    rd_nxt = '0;
    for (int c = 0; c < ZONE_COLS; c++)
      if (ptr_nxt == PW'(c)) rd_nxt = rd_bank[c];
  end

  always_ff @(posedge pixel_clk) begin
    if (!sys_rst) begin
      ptr        <= '0;
      zone_vld   <= 1'b0;
      zone_val   <= '0;
      zone_idx   <= '0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_done <= xfer & (zone_idx == IW'(ZONE_N - 1));
      if (band_end & ~accept) overflow <= 1'b1;
      if (accept) begin
        zone_vld <= 1'b1;
        ptr      <= '0;
        zone_val <= start_val;
        zone_idx <= base_idx;
      end else if (xfer) begin
        if (last) begin
          zone_vld <= 1'b0;
        end else begin
          ptr      <= ptr_nxt;
          zone_idx <= zone_idx + IW'(1);
          zone_val <= rd_nxt;
        end
      end
    end
  end

endmodule

// File: rtl/zone_max_accum.sv
// Per-frame peak brightness per backlight zone; accumulates one zone band at
// a time in a ping-pong bank and hands finished bands to zone_flush_ctrl.
module zone_max_accum
  import zone_max_accum_pkg::*;
#(
  parameter int H_ACTIVE  = 1920,
  parameter int V_ACTIVE  = 1080,
  parameter int V_START   = 1,
  parameter int ZONE_COLS = 16,
  parameter int ZONE_ROWS = 9
) (
  input  logic                                      pixel_clk,
  input  logic                                      sys_rst,
  input  logic                                      new_frame,
  input  logic                                      pix_vld,
  input  logic [10:0]                               row_cnt,
  input  logic [10:0]                               column_cnt,
  input  bright_t                                   pix_max,
  output logic                                      zone_vld,
  input  logic                                      zone_rdy,
  output bright_t                                   zone_val,
  output logic [idx_w(ZONE_COLS*ZONE_ROWS)-1:0]     zone_idx,
  output logic                                      frame_done,
  output logic                                      overflow
);

  localparam int ZW = H_ACTIVE / ZONE_COLS;
  localparam int ZH = V_ACTIVE / ZONE_ROWS;
  localparam int ZN = ZONE_COLS * ZONE_ROWS;
  localparam int IW = idx_w(ZN);
  localparam int CW = 11;

  localparam logic [CW-1:0] ROW_LO   = CW'(V_START);
  localparam logic [CW-1:0] ROW_HI   = CW'(V_START + V_ACTIVE);
  localparam logic [CW-1:0] COL_HI   = CW'(H_ACTIVE);
  localparam logic [CW-1:0] COL_LAST = CW'(H_ACTIVE - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ACCUM = 1'b1;

  logic [0:0]                       state;
  logic [CW-1:0]                    xsub, zx, ysub, zy, cur_xsub, cur_zx;
  logic                             acc_sel, accept;
  logic [1:0][ZONE_COLS-1:0][7:0]   bank;
  logic [ZONE_COLS-1:0][7:0]        acc_cur, acc_nxt, flush_data;
  logic                             pix_q, col_last, xwrap, ywrap, band_end;

  assign pix_q    = (state == ST_ACCUM) & ~new_frame & pix_vld &
                    (row_cnt >= ROW_LO) & (row_cnt < ROW_HI) & (column_cnt < COL_HI);
  // xsub/zx registers hold the position of the next pixel; column 0 restarts it.
  assign cur_xsub = (column_cnt == '0) ? '0 : xsub;
  assign cur_zx   = (column_cnt == '0) ? '0 : zx;
  assign col_last = (column_cnt == COL_LAST);
  assign xwrap    = (cur_xsub == CW'(ZW - 1));
  assign ywrap    = (ysub == CW'(ZH - 1));
  assign band_end = pix_q & col_last & ywrap;

  assign acc_cur    = bank[acc_sel];
  assign flush_data = bank[~acc_sel];

  for (genvar c = 0; c < ZONE_COLS; c++) begin : g_col
    assign acc_nxt[c] = new_frame ? 8'h00 :
                        (pix_q && cur_zx == CW'(c)) ?
                          ((ysub == '0) ? pix_max : bright_max(acc_cur[c], pix_max)) :
                        acc_cur[c];
  end

  always_ff @(posedge pixel_clk) begin
    if (!sys_rst) begin
      state   <= ST_IDLE;
      xsub    <= '0;
      zx      <= '0;
      ysub    <= '0;
      zy      <= '0;
      acc_sel <= 1'b0;
      bank    <= '0;
    end else begin
      bank[acc_sel] <= acc_nxt;
      if (new_frame || frame_done) state <= ST_ACCUM;
      if (new_frame) begin
        xsub <= '0;
        zx   <= '0;
        ysub <= '0;
        zy   <= '0;
      end else if (pix_q) begin
        if (xwrap) begin
          xsub <= '0;
          zx   <= cur_zx + CW'(1);
        end else begin
          xsub <= cur_xsub + CW'(1);
          zx   <= cur_zx;
        end
        if (col_last) begin
          if (ywrap) begin
            ysub <= '0;
            zy   <= (zy == CW'(ZONE_ROWS - 1)) ? '0 : zy + CW'(1);
          end else begin
            ysub <= ysub + CW'(1);
          end
        end
      end
      if (accept) acc_sel <= ~acc_sel;
    end
  end

  // Entry 0 of the band is handed over from acc_nxt so the band-end pixel
  // itself is included even when it lands in zone column 0.
  zone_flush_ctrl #(
    .ZONE_COLS (ZONE_COLS),
    .ZONE_N    (ZN),
    .IW        (IW)
  ) u_flush (
    .pixel_clk  (pixel_clk),
    .sys_rst    (sys_rst),
    .band_end   (band_end),
    .start_val  (acc_nxt[0]),
    .base_idx   (IW'(zy * ZONE_COLS)),
    .rd_bank    (flush_data),
    .accept     (accept),
    .zone_vld   (zone_vld),
    .zone_rdy   (zone_rdy),
    .zone_val   (zone_val),
    .zone_idx   (zone_idx),
    .frame_done (frame_done),
    .overflow   (overflow)
  );

endmodule

// File: tb/tb_zone_max_accum.sv
// Directed bench for zone_max_accum on an 8x4 frame split into 2x2 zones.
module tb_zone_max_accum;

  localparam int H = 8, V = 4, VS = 1, ZC = 2, ZR = 2;

  logic        pixel_clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic        new_frame = 1'b0;
  logic        pix_vld = 1'b0;
  logic [10:0] row_cnt = '0, column_cnt = '0;
  logic [7:0]  pix_max = '0;
  logic        zone_rdy = 1'b1;
  logic        zone_vld, frame_done, overflow;
  logic [7:0]  zone_val;
  logic [1:0]  zone_idx;

  int nchk = 0, nerr = 0, fd_cnt = 0;
  int got_val[$], got_idx[$];
  int ev[4], ei[4];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_val = '0;
  logic [1:0] prev_idx = '0;

  zone_max_accum #(
    .H_ACTIVE (H), .V_ACTIVE (V), .V_START (VS), .ZONE_COLS (ZC), .ZONE_ROWS (ZR)
  ) dut (
    .pixel_clk  (pixel_clk),
    .sys_rst    (sys_rst),
    .new_frame  (new_frame),
    .pix_vld    (pix_vld),
    .row_cnt    (row_cnt),
    .column_cnt (column_cnt),
    .pix_max    (pix_max),
    .zone_vld   (zone_vld),
    .zone_rdy   (zone_rdy),
    .zone_val   (zone_val),
    .zone_idx   (zone_idx),
    .frame_done (frame_done),
    .overflow   (overflow)
  );

  always #5 pixel_clk = ~pixel_clk;

  task automatic chk(input string tag, input int obs, input int exp);
    nchk++;
    if (obs != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Transfers, frame_done pulses and stall stability, sampled mid-cycle.
  always @(negedge pixel_clk) begin
    if (!sys_rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && zone_vld) begin
        chk("stall_val", zone_val, prev_val);
        chk("stall_idx", zone_idx, prev_idx);
      end
      if (zone_vld && zone_rdy) begin
        got_val.push_back(zone_val);
        got_idx.push_back(zone_idx);
      end
      if (frame_done) fd_cnt++;
      prev_stall = zone_vld && !zone_rdy;
      prev_val   = zone_val;
      prev_idx   = zone_idx;
    end
  end

  task automatic tick();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic pulse_nf();
    new_frame = 1'b1;
    tick();
    new_frame = 1'b0;
  endtask

  task automatic send_pix(input int r, input int c, input int v);
    pix_vld    = 1'b1;
    row_cnt    = 11'(r);
    column_cnt = 11'(c);
    pix_max    = 8'(v);
    tick();
    pix_vld    = 1'b0;
  endtask

  // mode 0: col+8*row, mode 1: all 7, mode 2: mode 0 plus out-of-range 255s
  task automatic drive_frame(input int mode);
    if (mode == 2) send_pix(0, 3, 255);
    for (int r = 0; r < V; r++) begin
      if (mode == 2 && r == 2) begin
        send_pix(5, 2, 255);
        send_pix(r + VS, 9, 255);
      end
      for (int c = 0; c < H; c++)
        send_pix(r + VS, c, (mode == 1) ? 7 : c + 8 * r);
    end
    if (mode == 2) send_pix(5, 0, 255);
  endtask

  task automatic clear_mon();
    got_val.delete();
    got_idx.delete();
    fd_cnt = 0;
  endtask

  task automatic check_out(input string tag, input int n, input int fd);
    for (int k = 0; k < 300 && got_val.size() < n; k++) tick();
    repeat (4) tick();
    chk({tag, "_n_zones"}, got_val.size(), n);
    for (int i = 0; i < n && i < got_val.size(); i++) begin
      chk({tag, "_zone_val"}, got_val[i], ev[i]);
      chk({tag, "_zone_idx"}, got_idx[i], ei[i]);
    end
    chk({tag, "_frame_done"}, fd_cnt, fd);
  endtask

  initial begin
    ei = '{0, 1, 2, 3};
    repeat (3) tick();
    chk("rst_zone_vld", zone_vld, 0);
    chk("rst_zone_val", zone_val, 0);
    chk("rst_zone_idx", zone_idx, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_overflow", overflow, 0);
    sys_rst = 1'b1;
    tick();

    // plain frame, downstream always ready
    clear_mon();
    pulse_nf();
    drive_frame(0);
    ev = '{11, 15, 27, 31};
    check_out("s1", 4, 1);
    chk("s1_overflow", overflow, 0);

    // same frame, ready toggling every cycle
    clear_mon();
    pulse_nf();
    fork
      drive_frame(0);
      for (int k = 0; k < 120; k++) begin
        tick();
        zone_rdy = ~zone_rdy;
      end
    join
    zone_rdy = 1'b1;
    check_out("s2", 4, 1);

    // out-of-range pixels carrying 255 must not leak in
    clear_mon();
    pulse_nf();
    drive_frame(2);
    check_out("s4", 4, 1);
    chk("s4_overflow", overflow, 0);

    // stalled flush makes band 1 drop
    clear_mon();
    zone_rdy = 1'b0;
    pulse_nf();
    fork
      drive_frame(0);
      begin
        repeat (35) tick();
        zone_rdy = 1'b1;
      end
    join
    ev = '{11, 15, 0, 0};
    check_out("s3", 2, 0);
    chk("s3_overflow", overflow, 1);
    repeat (10) tick();
    chk("s3_overflow_sticky", overflow, 1);

    // restart mid-band, then a flat frame
    clear_mon();
    pulse_nf();
    for (int c = 0; c < H; c++) send_pix(VS, c, 200);
    for (int c = 0; c < 4; c++) send_pix(VS + 1, c, 200);
    pulse_nf();
    drive_frame(1);
    ev = '{7, 7, 7, 7};
    check_out("s5", 4, 1);
    chk("s5_overflow_sticky", overflow, 1);

    // reset while a flush is stalled
    clear_mon();
    zone_rdy = 1'b0;
    pulse_nf();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < H; c++) send_pix(r + VS, c, c + 8 * r);
    chk("s6_vld_pre_rst", zone_vld, 1);
    chk("s6_val_pre_rst", zone_val, 11);
    sys_rst = 1'b0;
    tick();
    chk("s6_rst_zone_vld", zone_vld, 0);
    chk("s6_rst_zone_val", zone_val, 0);
    chk("s6_rst_zone_idx", zone_idx, 0);
    chk("s6_rst_overflow", overflow, 0);
    chk("s6_rst_frame_done", frame_done, 0);
    sys_rst  = 1'b1;
    zone_rdy = 1'b1;
    tick();

    // after reset the block idles until new_frame
    clear_mon();
    drive_frame(0);
    repeat (10) tick();
    chk("idle_n_zones", got_val.size(), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
